// File: rtl/xdma_pkg.sv
// xdma_pkg
//   Types and helpers shared by the XDMA write-path blocks.
//   - xdma_req_t / xdma_rsp_t : default reqrsp request/response structs
//   - arb_state_e             : write burst arbiter FSM states
//   - beat_cnt_t              : 9-bit beat counter used to police burst length
//   - wrapInc                 : index increment with wrap at a given count
package xdma_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic                 q_valid;
    logic                 p_ready;
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [3:0]           amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [2:0]           size;
  } xdma_req_t;

  typedef struct packed {
    logic                 q_ready;
    logic                 p_valid;
    logic [DataWidth-1:0] data;
    logic                 error;
  } xdma_rsp_t;

  typedef enum logic {
    ArbIdle,
    ArbLocked
  } arb_state_e;

  typedef logic [8:0] beat_cnt_t;

  localparam beat_cnt_t BeatCntMax = 9'h1FF;

  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/xdma_rr_pick.sv
// xdma_rr_pick
//   Combinational round-robin pick: returns the first asserted bit of valid_i
//   at or after rr_ptr_i, searching upward and wrapping at NumInp.
//   Ports:
//     valid_i     in   NumInp  request valid vector
//     rr_ptr_i    in   IdxW    index that has priority this cycle
//     gnt_o       out  IdxW    picked index (rr_ptr_i when nothing is valid)
//     any_valid_o out  1       at least one valid bit is set
module xdma_rr_pick #(
  parameter int unsigned NumInp = 2,
  localparam int unsigned IdxW  = $clog2(NumInp)
) (
  input  logic [NumInp-1:0] valid_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  output logic [IdxW-1:0]   gnt_o,
  output logic              any_valid_o
);

  int unsigned cand;

  // Walk the inputs starting at the pointer; the first hit wins. The wrap is a
  // conditional subtract so NumInp need not be a power of two.
  always_comb begin
    gnt_o       = rr_ptr_i;
    any_valid_o = 1'b0;
    cand        = 32'd0;
    for (int unsigned off = 0; off < NumInp; off++) begin
      cand = 32'(rr_ptr_i) + off;
      if (cand >= NumInp) begin
        cand = cand - NumInp;
      end
      if (!any_valid_o && valid_i[cand[IdxW-1:0]]) begin
        any_valid_o = 1'b1;
        gnt_o       = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/xdma_write_burst_arbiter.sv
// xdma_write_burst_arbiter
//   Shares one reqrsp write port between NumInp AXI write adapters. Grants are
//   round-robin and locked for a whole burst; the lock is released when the
//   last beat is accepted or when a burst reaches MaxBeats without a last.
//   Ports:
//     clk_i       in   1              clock
//     rst_ni      in   1              asynchronous active-low reset
//     in_req_i    in   NumInp x req   requests from the adapters
//     in_last_i   in   NumInp         last-beat flags, qualified by q_valid
//     in_rsp_o    out  NumInp x rsp   responses to the adapters (q_ready only)
//     out_req_o   out  req            arbitrated request to the datapath
//     out_last_o  out  1              last flag of the forwarded beat
//     out_rsp_i   in   rsp            response from the datapath
//     grant_idx_o out  IdxW           current or held grant index
//     busy_o      out  1              locked, or any adapter requesting
//     burst_err_o out  1              one-cycle pulse on burst overlength
module xdma_write_burst_arbiter
  import xdma_pkg::*;
#(
  parameter int unsigned NumInp   = 2,
  parameter int unsigned MaxBeats = 256,
  parameter type reqrsp_req_t     = xdma_req_t,
  parameter type reqrsp_rsp_t     = xdma_rsp_t,
  localparam int unsigned IdxW    = $clog2(NumInp)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  reqrsp_req_t       in_req_i [NumInp],
  input  logic [NumInp-1:0] in_last_i,
  output reqrsp_rsp_t       in_rsp_o [NumInp],
  output reqrsp_req_t       out_req_o,
  output logic              out_last_o,
  input  reqrsp_rsp_t       out_rsp_i,
  output logic [IdxW-1:0]   grant_idx_o,
  output logic              busy_o,
  output logic              burst_err_o
);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  beat_cnt_t         beat_cnt_q, beat_cnt_d;

  logic [NumInp-1:0] inValid;
  logic [IdxW-1:0]   pickIdx;
  logic              pickAny;
  logic [IdxW-1:0]   selIdx;
  logic              selActive;
  logic [IdxW-1:0]   nextPtr;
  logic              accept;
  logic              overLen;
  logic              unusedRspBits;

  for (genvar i = 0; i < NumInp; i++) begin : gen_valid
    assign inValid[i] = in_req_i[i].q_valid;
  end

  xdma_rr_pick #(
    .NumInp(NumInp)
  ) u_rr_pick (
    .valid_i    (inValid),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_o      (pickIdx),
    .any_valid_o(pickAny)
  );

  // While locked the held index is the only candidate, even with its valid low.
  always_comb begin
    if (state_q == ArbLocked) begin
      selIdx    = gnt_q;
      selActive = 1'b1;
    end else begin
      selIdx    = pickIdx;
      selActive = pickAny;
    end
  end

  // Mux the selected request out and route q_ready back to it alone. Valid and
  // ready are masked by rst_ni so no beat can be exchanged while in reset.
  always_comb begin
    out_req_o = '0;
    if (selActive) begin
      out_req_o = in_req_i[selIdx];
    end
    out_req_o.q_valid = selActive & rst_ni & in_req_i[selIdx].q_valid;
    out_req_o.p_ready = 1'b1;
    out_last_o        = in_last_i[selIdx] & out_req_o.q_valid;
    for (int i = 0; i < NumInp; i++) begin
      in_rsp_o[i]         = '0;
      in_rsp_o[i].q_ready = rst_ni & selActive & (selIdx == IdxW'(i)) & out_rsp_i.q_ready;
    end
  end

  assign accept      = out_req_o.q_valid & out_rsp_i.q_ready;
  assign overLen     = accept & ~out_last_o &
                       (({1'b0, beat_cnt_q} + 10'd1) == 10'(MaxBeats));
  assign nextPtr     = IdxW'(wrapInc(32'(selIdx), NumInp));
  assign grant_idx_o = selIdx;
  assign busy_o      = (state_q == ArbLocked) | (|inValid);

  // Write-only path: the datapath's response payload is intentionally dropped.
  assign unusedRspBits = ^{out_rsp_i.p_valid, out_rsp_i.data, out_rsp_i.error};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_o = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (pickAny) begin
          if (accept && (out_last_o || overLen)) begin
            rr_ptr_d    = nextPtr;
            beat_cnt_d  = '0;
            burst_err_o = overLen;
          end else if (accept) begin
            state_d    = ArbLocked;
            gnt_d      = selIdx;
            beat_cnt_d = 9'd1;
          end else begin
            // Not accepted yet: lock now so the presented request stays put.
            state_d    = ArbLocked;
            gnt_d      = selIdx;
            beat_cnt_d = '0;
          end
        end
      end
      ArbLocked: begin
        if (accept) begin
          if (out_last_o || overLen) begin
            state_d     = ArbIdle;
            rr_ptr_d    = nextPtr;
            beat_cnt_d  = '0;
            burst_err_o = overLen;
          end else if (beat_cnt_q != BeatCntMax) begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_xdma_write_burst_arbiter.sv
// tb_xdma_write_burst_arbiter
//   Directed bench for the write burst arbiter (NumInp=2, MaxBeats=4).
//   Expected beats are queued as stimulus is issued; a negedge monitor pops
//   and compares whenever the arbiter hands a beat to the datapath.
module tb_xdma_write_burst_arbiter;
  import xdma_pkg::*;

  localparam int unsigned NumInp        = 2;
  localparam int unsigned MaxBeats      = 4;
  localparam int unsigned PortW         = $clog2(NumInp);
  localparam int          TimeoutCycles = 100;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t expQ[$];
  beat_t monExp;
  int    errorCount = 0;
  int    checkCount = 0;
  logic  aDone;
  int    guard;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              inVld [NumInp];
  logic [31:0]       inDat [NumInp];
  logic [NumInp-1:0] inLast;
  logic              outReady;

  xdma_req_t         inReq [NumInp];
  xdma_rsp_t         inRsp [NumInp];
  xdma_req_t         outReq;
  xdma_rsp_t         outRsp;
  logic              outLast;
  logic [PortW-1:0]  grantIdx;
  logic              busy;
  logic              burstErr;
  logic              unusedTbBits;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      inReq[i]         = '0;
      inReq[i].q_valid = inVld[i];
      inReq[i].write   = 1'b1;
      inReq[i].addr    = 32'h1000 + 32'(i) * 32'h100;
      inReq[i].data    = inDat[i];
      inReq[i].strb    = '1;
      inReq[i].size    = 3'd2;
    end
    outRsp         = '0;
    outRsp.q_ready = outReady;
  end

  assign unusedTbBits = ^{outReq.addr, outReq.write, outReq.amo, outReq.strb,
                          outReq.size, outReq.p_ready,
                          inRsp[0].p_valid, inRsp[0].data, inRsp[0].error,
                          inRsp[1].p_valid, inRsp[1].data, inRsp[1].error};

  xdma_write_burst_arbiter #(
    .NumInp  (NumInp),
    .MaxBeats(MaxBeats)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_req_i   (inReq),
    .in_last_i  (inLast),
    .in_rsp_o   (inRsp),
    .out_req_o  (outReq),
    .out_last_o (outLast),
    .out_rsp_i  (outRsp),
    .grant_idx_o(grantIdx),
    .busy_o     (busy),
    .burst_err_o(burstErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int idx, input logic [31:0] data, input logic last,
                         input logic err);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    b.last = last;
    b.err  = err;
    expQ.push_back(b);
  endtask

  // Present one beat on port p and hold it until that port sees q_ready.
  task automatic sendBeat(input logic [PortW-1:0] p, input logic [31:0] d, input logic l);
    int waited = 0;
    inVld[p]  = 1'b1;
    inDat[p]  = d;
    inLast[p] = l;
    @(negedge clk_i);
    while (!inRsp[p].q_ready && waited < TimeoutCycles) begin
      @(negedge clk_i);
      waited++;
    end
    if (!inRsp[p].q_ready) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL handshake port %0d: got no q_ready, want q_ready within %0d cycles",
               p, TimeoutCycles);
    end
    @(posedge clk_i);
    #1;
    inVld[p] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [PortW-1:0] p, input int n,
                               input logic [31:0] base, input logic withLast);
    for (int k = 0; k < n; k++) begin
      sendBeat(p, base + 32'(k), withLast && (k == n - 1));
    end
  endtask

  task automatic resetDut();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (outReq.q_valid && outRsp.q_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected beat: got data 0x%0h on port %0d, want no beat",
                   outReq.data, grantIdx);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("beat grant", 32'(grantIdx), 32'(monExp.idx));
          checkOutput("beat data", outReq.data, monExp.data);
          checkOutput("beat last", 32'(outLast), 32'(monExp.last));
          checkOutput("beat burst_err", 32'(burstErr), 32'(monExp.err));
        end
      end else if (burstErr) begin
        checkOutput("burst_err without beat", 32'(burstErr), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 100000 time units");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    for (int i = 0; i < NumInp; i++) begin
      inVld[i] = 1'b0;
      inDat[i] = 32'h0;
    end
    inLast   = '0;
    outReady = 1'b1;
    rst_ni   = 1'b0;

    // Reset state, with a pending request that must not leak through
    inVld[0] = 1'b1;
    inDat[0] = 32'hDEAD;
    @(negedge clk_i);
    checkOutput("reset out q_valid", 32'(outReq.q_valid), 32'h0);
    checkOutput("reset in0 q_ready", 32'(inRsp[0].q_ready), 32'h0);
    checkOutput("reset in1 q_ready", 32'(inRsp[1].q_ready), 32'h0);
    checkOutput("reset burst_err", 32'(burstErr), 32'h0);
    checkOutput("reset grant_idx", 32'(grantIdx), 32'h0);
    inVld[0] = 1'b0;
    @(negedge clk_i);
    checkOutput("reset busy", 32'(busy), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: single 4-beat burst on in0
    for (int k = 0; k < 4; k++) pushExp(0, 32'h100 + 32'(k), k == 3, 1'b0);
    applyStimulus(1'b0, 4, 32'h100, 1'b1);
    @(negedge clk_i);
    checkOutput("t1 rr_ptr after burst", 32'(grantIdx), 32'h1);
    checkOutput("t1 busy idle", 32'(busy), 32'h0);

    // 2: both inputs start 2-beat bursts together
    resetDut();
    pushExp(0, 32'h200, 1'b0, 1'b0);
    pushExp(0, 32'h201, 1'b1, 1'b0);
    pushExp(1, 32'h210, 1'b0, 1'b0);
    pushExp(1, 32'h211, 1'b1, 1'b0);
    fork
      applyStimulus(1'b0, 2, 32'h200, 1'b1);
      applyStimulus(1'b1, 2, 32'h210, 1'b1);
    join

    // 3: in1 burst stalled by the datapath while in0 requests
    outReady = 1'b0;
    pushExp(1, 32'h300, 1'b0, 1'b0);
    pushExp(1, 32'h301, 1'b1, 1'b0);
    pushExp(0, 32'h400, 1'b1, 1'b0);
    fork
      applyStimulus(1'b1, 2, 32'h300, 1'b1);
      begin
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 1, 32'h400, 1'b1);
      end
      begin
        repeat (3) begin
          @(negedge clk_i);
          checkOutput("t3 stall grant", 32'(grantIdx), 32'h1);
          checkOutput("t3 stall data", outReq.data, 32'h300);
          checkOutput("t3 stall q_valid", 32'(outReq.q_valid), 32'h1);
          checkOutput("t3 stall busy", 32'(busy), 32'h1);
        end
        @(posedge clk_i);
        #1;
        outReady = 1'b1;
        @(negedge clk_i);
        checkOutput("t3 in0 blocked", 32'(inRsp[0].q_ready), 32'h0);
        checkOutput("t3 in1 routed", 32'(inRsp[1].q_ready), 32'h1);
      end
    join

    // 4: in0 pauses mid-burst while in1 waits
    aDone = 1'b0;
    guard = 0;
    for (int k = 0; k < 4; k++) pushExp(0, 32'h500 + 32'(k), k == 3, 1'b0);
    pushExp(1, 32'h600, 1'b1, 1'b0);
    fork
      begin
        sendBeat(1'b0, 32'h500, 1'b0);
        sendBeat(1'b0, 32'h501, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        sendBeat(1'b0, 32'h502, 1'b0);
        sendBeat(1'b0, 32'h503, 1'b1);
        aDone = 1'b1;
      end
      begin
        @(posedge clk_i);
        #1;
        applyStimulus(1'b1, 1, 32'h600, 1'b1);
      end
      begin
        while (!aDone && guard < 50) begin
          @(negedge clk_i);
          if (!aDone) begin
            checkOutput("t4 in1 held off", 32'(inRsp[1].q_ready), 32'h0);
            checkOutput("t4 grant held", 32'(grantIdx), 32'h0);
          end
          guard++;
        end
      end
    join

    // 5: overlength burst on in0 (MaxBeats=4), in1 waiting
    for (int k = 0; k < 4; k++) pushExp(0, 32'h700 + 32'(k), 1'b0, k == 3);
    pushExp(1, 32'h800, 1'b1, 1'b0);
    pushExp(0, 32'h704, 1'b0, 1'b0);
    fork
      applyStimulus(1'b0, 5, 32'h700, 1'b0);
      begin
        @(posedge clk_i);
        #1;
        applyStimulus(1'b1, 1, 32'h800, 1'b1);
      end
    join
    @(negedge clk_i);
    checkOutput("t5 busy while locked", 32'(busy), 32'h1);

    // 6: reset in the middle of a burst
    resetDut();
    pushExp(0, 32'h8F0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1, 32'h8F0, 1'b1);
    pushExp(0, 32'h900, 1'b0, 1'b0);
    pushExp(0, 32'h901, 1'b0, 1'b0);
    sendBeat(1'b0, 32'h900, 1'b0);
    sendBeat(1'b0, 32'h901, 1'b0);
    inVld[0]  = 1'b1;
    inDat[0]  = 32'h902;
    inLast[0] = 1'b0;
    inVld[1]  = 1'b1;
    inDat[1]  = 32'hB00;
    inLast[1] = 1'b1;
    rst_ni    = 1'b0;
    @(negedge clk_i);
    checkOutput("t6 reset q_valid", 32'(outReq.q_valid), 32'h0);
    checkOutput("t6 reset in0 q_ready", 32'(inRsp[0].q_ready), 32'h0);
    checkOutput("t6 reset in1 q_ready", 32'(inRsp[1].q_ready), 32'h0);
    @(posedge clk_i);
    #1;
    inDat[0]  = 32'hA00;
    inLast[0] = 1'b1;
    pushExp(0, 32'hA00, 1'b1, 1'b0);
    pushExp(1, 32'hB00, 1'b1, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("t6 first grant", 32'(grantIdx), 32'h0);
    checkOutput("t6 first data", outReq.data, 32'hA00);
    @(posedge clk_i);
    #1;
    inVld[0] = 1'b0;
    sendBeat(1'b1, 32'hB00, 1'b1);

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
